// File: rtl/apb_master.sv
`timescale 1ns/1ps
// APB4 requester: turns one outstanding command into a SETUP/ACCESS transfer,
// returning read data and error status, with a watchdog on stalled completers.
module apb_master #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                preset_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_strb_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic                pslverr,
    input  logic [DATA_W-1:0]   prdata
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_done;
    logic                w_abort;
    logic                w_expire;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_rsp_timeout;

    assign w_accept = (r_state == S_IDLE) && cmd_valid_i;
    // Expires on the last permitted wait cycle; a zero TIMEOUT never expires.
    assign w_expire = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!preset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                // pready wins over an expiring watchdog in the same cycle
                if (pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_expire) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!preset_n) begin
            r_cnt         <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_psel      <= (w_state_nxt != S_IDLE);
            r_penable   <= (w_state_nxt == S_ACCESS);
            r_rsp_valid <= w_done | w_abort;

            // Command fields held on the bus until the next accept
            if (w_accept) begin
                r_pwrite <= cmd_write_i;
                r_paddr  <= cmd_addr_i;
                r_pwdata <= cmd_wdata_i;
                r_pstrb  <= cmd_write_i ? cmd_strb_i : '0;
            end

            if (w_accept) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !pready && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_done) begin
                r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                r_rsp_err     <= pslverr;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready_o   = (r_state == S_IDLE);
    assign psel          = r_psel;
    assign penable       = r_penable;
    assign pwrite        = r_pwrite;
    assign paddr         = r_paddr;
    assign pwdata        = r_pwdata;
    assign pstrb         = r_pstrb;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: doc/apb_master.md
# apb_master

APB4 requester that converts a single-outstanding command/response interface into APB SETUP/ACCESS transfers toward any APB completer, such as the UART register block. It serves test harnesses, CPU-less bring-up logic and DMA-style engines that need to program or poll peripheral registers. It registers each command, sequences `psel`/`penable`, honours `pready` wait states, and returns read data and error status. A watchdog aborts transfers whose completer never asserts `pready`.

## Interface
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width; strobe width is DATA_W/8
- TIMEOUT, 16, maximum ACCESS cycles with `pready` low before abort; 0 disables the watchdog
- clk  in  1  single clock; all logic rising-edge
- preset_n  in  1  synchronous, active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  target address
- cmd_wdata_i  in  DATA_W  write data
- cmd_strb_i  in  DATA_W/8  write byte strobes
- rsp_valid_o  out  1  one-cycle pulse: transfer finished
- rsp_rdata_o  out  DATA_W  read data, valid with rsp_valid_o
- rsp_err_o  out  1  pslverr or timeout, valid with rsp_valid_o
- rsp_timeout_o  out  1  watchdog abort, valid with rsp_valid_o
- psel, penable, pwrite  out  1  APB controls
- paddr  out  ADDR_W;  pwdata  out  DATA_W;  pstrb  out  DATA_W/8
- pready, pslverr  in  1;  prdata  in  DATA_W

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: `cmd_ready_o`=1 (decoded from state). When cmd_valid_i=1, register addr, write, wdata and strb, then go to SETUP.
- The strobe register is forced to 0 on reads, per the APB4 rule.
- SETUP: psel=1, penable=0. Always lasts exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1.
  - pready=1: capture prdata (reads only; writes return 0) and pslverr, pulse rsp_valid_o, go to IDLE.
  - pready=0: increment the wait counter.
- Watchdog: when the wait counter reaches TIMEOUT with pready still 0:
  - drop psel/penable and go to IDLE;
  - pulse rsp_valid_o with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
- pready=1 in the same cycle the counter would expire takes priority as a normal completion.
- pslverr and prdata are ignored unless pready=1 in ACCESS.
- paddr, pwrite, pwdata and pstrb are stable from SETUP through the completing ACCESS cycle. They retain their last values in IDLE.
- No response backpressure: the requester must accept rsp_valid_o. Only one transfer is outstanding at a time.
- Wait counter: $clog2(TIMEOUT+1) bits, cleared on entry to SETUP, saturating.
- Reset (preset_n=0 at a clock edge):
  - state goes to IDLE; psel, penable, pwrite, rsp_valid_o, rsp_err_o and rsp_timeout_o go to 0;
  - paddr, pwdata, pstrb, rsp_rdata_o and the counter go to 0;
  - cmd_ready_o=1 after the reset edge.
  - Reset during SETUP or ACCESS abandons the transfer silently; no response is issued.

## Timing
- Command handshake in cycle N (IDLE, valid&ready): SETUP in N+1, ACCESS from N+2.
- pready=1 sampled at the end of cycle N+2+W (W wait states): rsp_valid_o is high in cycle N+3+W and the FSM is in IDLE in N+3+W. cmd_ready_o=1 in N+3+W.
- Minimum command-to-command spacing is therefore 3 cycles; back-to-back commands must not insert extra IDLE cycles beyond this.
- Timeout with TIMEOUT=T: ACCESS lasts T cycles with pready=0, then psel drops and rsp_valid_o pulses in the following cycle.
- All outputs are registered except cmd_ready_o, which is decoded from state only and has no input-to-output combinational path.

## Test plan
- Zero-wait write, addr 0x004, wdata 0xA5A5_0001, strb 0xF: psel high for 2 cycles, penable in cycle 2, pstrb=0xF. rsp_valid 3 cycles after the handshake with err=0 and rdata=0.
- Read at 0x010 with 3 wait states, prdata=0x1234_5678: ACCESS held 4 cycles with paddr stable and pstrb=0. Response carries rdata=0x1234_5678, err=0.
- Write with pslverr=1 on the pready cycle: rsp_err_o=1, rsp_timeout_o=0. Also drive pslverr=1 while pready=0: it has no effect.
- TIMEOUT=16 with pready held low: psel drops after 16 ACCESS cycles. Response: err=1, timeout=1, rdata=0. Next command proceeds normally. With TIMEOUT=0 and 100 waits, no abort occurs.
- cmd_valid held high for 4 queued commands: each transfer starts exactly 3 cycles after the previous handshake, with correct per-command addr/data.
- preset_n low mid-ACCESS: the next cycle shows psel=penable=0, rsp_valid never pulses, cmd_ready_o=1. A read afterwards completes normally.
